btn_bounce_gen: RTL and testbench
=================================

BTN_BOUNCE_GEN -- requirements
Module: btn_bounce_gen

Interface
REQ-001 Parameter BOUNCES, default 4, meaning number of glitches emitted before the final edge (0..255; 0 = clean edge).
REQ-002 Parameter GLITCH_W, default 3, meaning width of the glitch-duration field (1..7).
REQ-003 Parameter SETTLE_CYCLES, default 16, meaning cycles the final level is held before completion (1..65535).
REQ-004 Parameter LFSR_SEED, default 8'hA5, meaning nonzero LFSR reset value.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_press  input  1  command target: 1 = press (btn_n low), 0 = release (btn_n high).
REQ-009 cmd_ready  output  1  high only in IDLE.
REQ-010 abort  input  1  terminate the active sequence.
REQ-011 btn_n  output  1  emulated bouncy active-low button, registered.
REQ-012 busy  output  1  high in BOUNCE or SETTLE.
REQ-013 done  output  1  one-cycle completion pulse, registered.

Function
REQ-014 The FSM SHALL have states IDLE, BOUNCE and SETTLE.
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; cmd_valid SHALL be ignored in any other state.
REQ-016 On acceptance, when the target equals the current btn_n level, the FSM SHALL go to SETTLE with btn_n unchanged.
REQ-017 On acceptance, when the target differs and BOUNCES > 0, the FSM SHALL go to BOUNCE and drive btn_n to the target level on the next edge.
REQ-018 On acceptance, when the target differs and BOUNCES = 0, the FSM SHALL drive btn_n to the target level on the next edge and go to SETTLE.
REQ-019 BOUNCE SHALL emit BOUNCES glitches: each glitch is a target-level phase of d cycles followed by an old-level phase of d cycles, with d reloaded per phase.
REQ-020 The edge that ends the last old-level phase SHALL drive btn_n to the target level and enter SETTLE.
REQ-021 SETTLE SHALL hold btn_n for SETTLE_CYCLES cycles, then return to IDLE with done high for exactly one cycle, coincident with cmd_ready = 1.
REQ-022 Phase length d SHALL be in the range 1..2^GLITCH_W; counters SHALL be sized so that no wrap occurs within the parameter limits.
REQ-023 abort in BOUNCE or SETTLE SHALL, on the next edge, drive btn_n to the target level, enter IDLE and pulse done.
REQ-024 abort in IDLE SHALL be ignored.
REQ-025 When abort and the end of a phase coincide, abort SHALL take priority.
REQ-026 btn_n SHALL change only on phase boundaries, the final edge, or abort; it SHALL be glitch-free (registered).

Reset
REQ-027 Asserting rst_n low SHALL immediately set: state IDLE, btn_n = 1, busy = 0, done = 0, cmd_ready = 1, all counters 0, LFSR = LFSR_SEED.
REQ-028 Reset during BOUNCE or SETTLE SHALL abandon the sequence with no done pulse.
REQ-029 Reset deassertion SHALL be synchronised to clk; the first command SHALL be accepted no earlier than the second edge after deassertion.

Configuration
REQ-030 With macro BTN_BOUNCE_LFSR_EN defined: d SHALL equal lfsr[GLITCH_W-1:0] + 1.
REQ-031 With BTN_BOUNCE_LFSR_EN defined: the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) SHALL advance once per phase load and is never cleared by commands.
REQ-032 Without BTN_BOUNCE_LFSR_EN: d SHALL be fixed at 2^(GLITCH_W-1), and no LFSR SHALL be instantiated.

Verification (defaults, macro undefined unless stated)
REQ-033 Press accepted at edge 0: btn_n changes at edges 1, 5, 9, ..., 29; final low at edge 33; done at edge 49 only; 5 falling and 4 rising btn_n edges.
REQ-034 Release after the press, BOUNCES=0: btn_n rises at edge 1 after acceptance; done 16 cycles later; no other btn_n edges.
REQ-035 Press while btn_n is already low: btn_n constant; done 16 cycles after acceptance.
REQ-036 abort at edge 10 of a press: btn_n = 0 at edge 11, done at edge 11, cmd_ready = 1, no further edges.
REQ-037 rst_n low during SETTLE: btn_n = 1, busy = 0 immediately; no done pulse; cmd_valid held high during busy is never accepted.
REQ-038 Macro defined, 50 press/release commands: every d in 1..8; btn_n sequence matches the LFSR reference model; every settled level is held for 16 cycles.

Source files
------------

// File: rtl/btn_bounce_gen.sv
// btn_bounce_gen: emulates a bouncy active-low push button driven by press/release commands.
// Define BTN_BOUNCE_LFSR_EN for pseudo-random glitch widths; otherwise every phase is 2^(GLITCH_W-1) cycles.
module btn_bounce_gen #(
  parameter int          BOUNCES       = 4,
  parameter int          GLITCH_W      = 3,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_press,
  input  logic abort,
  output logic cmd_ready,
  output logic btn_n,
  output logic busy,
  output logic done
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BOUNCE = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [8:0] LAST   = 9'(2 * BOUNCES);
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [8:0]  ph;
  logic [15:0] d_m1;
  logic [1:0]  rs;
  logic        tgt;
  logic        same;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign same      = ~cmd_press == btn_n;
`ifdef BTN_BOUNCE_LFSR_EN
  logic [7:0] lfsr;
  logic       load;
  assign load = state == BOUNCE && !abort && cnt == 16'd0 && ph != LAST;
  assign d_m1 = 16'(lfsr[GLITCH_W-1:0]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= LFSR_SEED;
    else if (load) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
  assign d_m1 = 16'((1 << (GLITCH_W - 1)) - 1);
`endif
  // ph counts btn_n transitions; even phases drive the target level, odd ones the old level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ph    <= '0;
      tgt   <= 1'b1;
      btn_n <= 1'b1;
      done  <= 1'b0;
      rs    <= '0;
    end else begin
      rs   <= {rs[0], 1'b1};
      done <= 1'b0;
      if (state != IDLE && abort) begin
        btn_n <= tgt;
        state <= IDLE;
        done  <= 1'b1;
        cnt   <= '0;
        ph    <= '0;
      end else if (state == IDLE) begin
        if (cmd_valid && rs[1]) begin
          tgt   <= ~cmd_press;
          state <= same ? SETTLE : BOUNCE;
          cnt   <= same ? 16'(SETTLE_CYCLES - 1) : 16'd0;
          ph    <= '0;
        end
      end else if (cnt != 16'd0) cnt <= cnt - 16'd1;
      else if (state == SETTLE) begin
        state <= IDLE;
        done  <= 1'b1;
      end else if (ph == LAST) begin
        btn_n <= tgt;
        state <= SETTLE;
        cnt   <= 16'(SETTLE_CYCLES - 1);
      end else begin
        btn_n <= ph[0] ? ~tgt : tgt;
        cnt   <= d_m1;
        ph    <= ph + 9'd1;
      end
    end
endmodule

// File: tb/tb_btn_bounce_gen.sv
// tb_btn_bounce_gen: directed + randomized checks of btn_bounce_gen against a queue-based timeline model.
module tb_btn_bounce_gen;
  localparam int         B    = 4;
  localparam int         GW   = 3;
  localparam int         SC   = 16;
  localparam logic [7:0] SEED = 8'hA5;
  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_press = 0, abort = 0;
  logic cmd_ready, btn_n, busy, done;
  int n_tests = 0, n_fail = 0;
  logic [2:0] q[$];
  logic [2:0] exp_e = 3'b100;
  logic cur = 1, mtgt = 1;
  logic [7:0] ml = SEED;
  int chg[$];
  int done_edge, falls, rises;

  btn_bounce_gen #(.BOUNCES(B), .GLITCH_W(GW), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_press(cmd_press), .abort(abort),
    .cmd_ready(cmd_ready), .btn_n(btn_n), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic next_d(output int d);
`ifdef BTN_BOUNCE_LFSR_EN
    d  = int'(ml & 8'((1 << GW) - 1)) + 1;
    ml = {ml[6:0], ^(ml & 8'hB8)};
`else
    d = 1 << (GW - 1);
`endif
  endtask

  // Timeline of {btn_n, busy, done} after each edge, starting with the acceptance edge
  task automatic build(input logic t);
    int d;
    q.delete();
    q.push_back({cur, 2'b10});
    if (t == cur) repeat (SC - 1) q.push_back({cur, 2'b10});
    else begin
      for (int g = 0; g < B; g++)
        for (int h = 0; h < 2; h++) begin
          next_d(d);
          repeat (d) q.push_back({h ? cur : t, 2'b10});
        end
      repeat (SC) q.push_back({t, 2'b10});
    end
    q.push_back({t, 2'b01});
    mtgt = t;
    cur  = t;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      exp_e = 3'b100;
      cur   = 1;
      ml    = SEED;
    end else if (q.size() > 0) begin
      if (abort) begin
        q.delete();
        exp_e = {mtgt, 2'b01};
      end else exp_e = q.pop_front();
    end else if (cmd_valid) begin
      build(~cmd_press);
      exp_e = q.pop_front();
    end else exp_e = {cur, 2'b00};
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("btn_n", btn_n, exp_e[2]);
      check("busy", busy, exp_e[1]);
      check("done", done, exp_e[0]);
      check("cmd_ready", cmd_ready, !exp_e[1]);
    end
  end

  task automatic run_cmd(input logic p, input int ab);
    logic prev;
    chg.delete();
    done_edge = -1;
    falls = 0;
    rises = 0;
    @(negedge clk);
    cmd_valid = 1;
    cmd_press = p;
    prev = btn_n;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    for (int e = 1; e <= 200 && done_edge < 0; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (btn_n != prev) begin
        chg.push_back(e);
        if (btn_n) rises++; else falls++;
      end
      prev = btn_n;
      if (done) done_edge = e;
      abort = (e == ab);
    end
    abort = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_btn_n", btn_n, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    rst_n = 1;
    repeat (5) @(negedge clk);
`ifndef BTN_BOUNCE_LFSR_EN
    run_cmd(1, -1);
    check("A_nchg", chg.size(), 9);
    for (int i = 0; i < chg.size(); i++) check("A_edge", chg[i], 1 + 4 * i);
    check("A_falls", falls, 5);
    check("A_rises", rises, 4);
    check("A_done", done_edge, 49);
`else
    run_cmd(1, -1);
`endif
    run_cmd(1, -1);
    check("B_nchg", chg.size(), 0);
    check("B_done", done_edge, 16);
    check("B_btn", btn_n, 0);
`ifndef BTN_BOUNCE_LFSR_EN
    run_cmd(0, -1);
    check("C_nchg", chg.size(), 9);
    check("C_rises", rises, 5);
    check("C_done", done_edge, 49);
    run_cmd(1, 10);
    check("D_nchg", chg.size(), 3);
    check("D_done", done_edge, 11);
    check("D_btn", btn_n, 0);
    check("D_ready", cmd_ready, 1);
`else
    run_cmd(0, -1);
    run_cmd(1, 10);
    check("D_btn", btn_n, 0);
    check("D_ready", cmd_ready, 1);
`endif
    // release command held valid through BOUNCE, then reset mid-SETTLE
    @(negedge clk);
    cmd_valid = 1;
    cmd_press = 0;
`ifndef BTN_BOUNCE_LFSR_EN
    repeat (40) @(negedge clk);
`else
    for (int i = 0; i < 300 && !(busy && btn_n && q.size() > 2 && q.size() < SC); i++) @(negedge clk);
`endif
    #2 rst_n = 0;
    #1;
    check("R_btn_n", btn_n, 1);
    check("R_busy", busy, 0);
    check("R_done", done, 0);
    cmd_valid = 0;
    repeat (3) begin
      @(negedge clk);
      check("R_nodone", done, 0);
    end
    rst_n = 1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_press = 1'($urandom_range(0, 1));
      abort     = $urandom_range(0, 59) == 0;
    end
    @(negedge clk);
    cmd_valid = 0;
    abort = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
